// File: rtl/maint_scheduler_pkg.sv
// Shared maintenance constants and the saturating refresh-pending update
// used by the maintenance request scheduler.
package maint_scheduler_pkg;

    localparam int CNT_WIDTH     = 28;
    localparam int DEF_MAX_PEND  = 8;
    localparam int DEF_URGENT_TH = 6;

    localparam logic [CNT_WIDTH-1:0] DEF_TREFI = 28'd7800;
    localparam logic [CNT_WIDTH-1:0] DEF_TZQI  = 28'd1000000;
    localparam logic [CNT_WIDTH-1:0] DEF_TPRI  = 28'd50000;

    // Returns {overflow_event, next_count}; simultaneous tick and ack cancel.
    function automatic logic [4:0] pend_step(input logic [3:0] cur,
                                             input logic       tick,
                                             input logic       ack,
                                             input logic [3:0] max_p);
        logic [4:0] res;
        case ({tick, ack})
            2'b10: begin
                if (cur == max_p) begin
                    res = {1'b1, cur};
                end else begin
                    res = {1'b0, cur + 4'd1};
                end
            end
            2'b01: begin
                if (cur == 4'd0) begin
                    res = {1'b0, cur};
                end else begin
                    res = {1'b0, cur - 4'd1};
                end
            end
            default: res = {1'b0, cur};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/maint_scheduler_timer.sv
// Reloadable down counter issuing a one-cycle tick every `interval` cycles
// while enabled; held at its reload value when disabled or interval is 0.
module maint_timer
    import maint_scheduler_pkg::*;
#(
    parameter int W = CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] interval,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         tick_s;

    // Next count and tick; a zero count (after reset) loads without ticking.
    always_comb begin
        cnt_d  = cnt_q;
        tick_s = 1'b0;
        if (!en || (interval == '0)) begin
            cnt_d = interval;
        end else if (cnt_q == W'(1)) begin
            tick_s = 1'b1;
            cnt_d  = interval;
        end else if (cnt_q == '0) begin
            cnt_d = interval;
        end else begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/maint_scheduler.sv
// Periodic maintenance request scheduler: refresh, ZQ-short and periodic read.
// Define ZQ_CAL_EN to build the ZQ timer and request path; otherwise zq_req is 0.
module maint_scheduler #(
    parameter int MAX_PEND  = maint_scheduler_pkg::DEF_MAX_PEND,
    parameter int URGENT_TH = maint_scheduler_pkg::DEF_URGENT_TH,
    parameter int CNT_WIDTH = maint_scheduler_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 maint_en,
    input  logic [CNT_WIDTH-1:0] trefi,
    input  logic [CNT_WIDTH-1:0] tzq_int,
    input  logic [CNT_WIDTH-1:0] tpr_int,
    output logic                 autoref_req,
    input  logic                 autoref_ack,
    output logic                 zq_req,
    input  logic                 zq_ack,
    output logic                 pr_rd_req,
    input  logic                 periodic_read_lock,
    output logic [3:0]           ref_pending,
    output logic                 ref_urgent,
    output logic                 ref_overflow
);
    import maint_scheduler_pkg::*;

    logic       ref_tick_s;
    logic       pr_tick_s;
    logic       lock_rise_s;
    logic       ovf_set_s;

    logic [3:0] pend_q, pend_d;
    logic       ovf_q, ovf_d;
    logic       urgent_q, urgent_d;
    logic       pr_pend_q, pr_pend_d;
    logic       lock_q, lock_d;
    logic       autoref_req_q, autoref_req_d;
    logic       pr_rd_req_q, pr_rd_req_d;

    maint_timer #(.W(CNT_WIDTH)) u_ref_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (maint_en),
        .interval (trefi),
        .tick     (ref_tick_s)
    );

    maint_timer #(.W(CNT_WIDTH)) u_pr_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (maint_en),
        .interval (tpr_int),
        .tick     (pr_tick_s)
    );

    assign lock_rise_s = periodic_read_lock & ~lock_q;

    // Refresh bookkeeping and periodic-read request; urgency masks the lower-priority reads.
    always_comb begin
        {ovf_set_s, pend_d} = pend_step(pend_q, ref_tick_s, autoref_ack, 4'(MAX_PEND));
        ovf_d    = ovf_q | ovf_set_s;
        urgent_d = (pend_d >= 4'(URGENT_TH));
        lock_d   = periodic_read_lock;
        if (pr_tick_s) begin
            pr_pend_d = 1'b1;
        end else if (lock_rise_s) begin
            pr_pend_d = 1'b0;
        end else begin
            pr_pend_d = pr_pend_q;
        end
        autoref_req_d = (pend_d != 4'd0);
        pr_rd_req_d   = pr_pend_d & ~urgent_d & ~periodic_read_lock;
    end

    // Refresh, periodic-read and request state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= 4'd0;
            ovf_q         <= 1'b0;
            urgent_q      <= 1'b0;
            pr_pend_q     <= 1'b0;
            lock_q        <= 1'b0;
            autoref_req_q <= 1'b0;
            pr_rd_req_q   <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            ovf_q         <= ovf_d;
            urgent_q      <= urgent_d;
            pr_pend_q     <= pr_pend_d;
            lock_q        <= lock_d;
            autoref_req_q <= autoref_req_d;
            pr_rd_req_q   <= pr_rd_req_d;
        end
    end

`ifdef ZQ_CAL_EN
    logic zq_tick_s;
    logic zq_pend_q, zq_pend_d;
    logic zq_req_q, zq_req_d;

    maint_timer #(.W(CNT_WIDTH)) u_zq_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (maint_en),
        .interval (tzq_int),
        .tick     (zq_tick_s)
    );

    // ZQ pending flag: a tick wins over a same-cycle ack.
    always_comb begin
        if (zq_tick_s) begin
            zq_pend_d = 1'b1;
        end else if (zq_ack) begin
            zq_pend_d = 1'b0;
        end else begin
            zq_pend_d = zq_pend_q;
        end
        zq_req_d = zq_pend_d & ~urgent_d;
    end

    // ZQ state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zq_pend_q <= 1'b0;
            zq_req_q  <= 1'b0;
        end else begin
            zq_pend_q <= zq_pend_d;
            zq_req_q  <= zq_req_d;
        end
    end

    assign zq_req = zq_req_q;
`else
    logic unused_zq_s;
    assign unused_zq_s = ^{tzq_int, zq_ack};
    assign zq_req      = 1'b0;
`endif

    assign autoref_req  = autoref_req_q;
    assign pr_rd_req    = pr_rd_req_q;
    assign ref_pending  = pend_q;
    assign ref_urgent   = urgent_q;
    assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_maint_scheduler.sv
// Self-checking bench for maint_scheduler: directed scenarios plus randomized
// traffic, every cycle compared against a cycle-level behavioural model.
module tb_maint_scheduler;

    localparam int CW = 28;
`ifdef ZQ_CAL_EN
    localparam bit ZQ_ON = 1'b1;
`else
    localparam bit ZQ_ON = 1'b0;
`endif
    localparam int MAXP = 8;
    localparam int URG  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          maint_en = 1'b0;
    logic [CW-1:0] trefi = '0;
    logic [CW-1:0] tzq_int = '0;
    logic [CW-1:0] tpr_int = '0;
    logic          autoref_ack = 1'b0;
    logic          zq_ack = 1'b0;
    logic          periodic_read_lock = 1'b0;
    logic          autoref_req, zq_req, pr_rd_req, ref_urgent, ref_overflow;
    logic [3:0]    ref_pending;

    maint_scheduler dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .maint_en           (maint_en),
        .trefi              (trefi),
        .tzq_int            (tzq_int),
        .tpr_int            (tpr_int),
        .autoref_req        (autoref_req),
        .autoref_ack        (autoref_ack),
        .zq_req             (zq_req),
        .zq_ack             (zq_ack),
        .pr_rd_req          (pr_rd_req),
        .periodic_read_lock (periodic_read_lock),
        .ref_pending        (ref_pending),
        .ref_urgent         (ref_urgent),
        .ref_overflow       (ref_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: remaining cycles per timer (0 = not yet loaded), counts and flags.
    int m_left[3];
    int m_pend;
    bit m_ovf, m_zq, m_pr, m_lockq;
    bit m_areq, m_zreq, m_preq, m_urg;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_left[i] = 0;
        m_pend = 0; m_ovf = 0; m_zq = 0; m_pr = 0; m_lockq = 0;
        m_areq = 0; m_zreq = 0; m_preq = 0; m_urg = 0;
    endtask

    function automatic int ival(input int i);
        case (i)
            0:       return int'(trefi);
            1:       return int'(tzq_int);
            default: return int'(tpr_int);
        endcase
    endfunction

    function automatic bit m_tick(input int i);
        return maint_en && (ival(i) != 0) && (m_left[i] == 1);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        bit t[3];
        bit rise;
        for (int i = 0; i < 3; i++) begin
            t[i] = m_tick(i);
            if (!maint_en || ival(i) == 0 || m_left[i] <= 1) m_left[i] = ival(i);
            else m_left[i] = m_left[i] - 1;
        end
        if (!ZQ_ON) t[1] = 0;
        if (t[0] && !autoref_ack) begin
            if (m_pend == MAXP) m_ovf = 1;
            else m_pend++;
        end else if (autoref_ack && !t[0] && m_pend > 0) begin
            m_pend--;
        end
        if (ZQ_ON) begin
            if (t[1]) m_zq = 1;
            else if (zq_ack) m_zq = 0;
        end
        rise = periodic_read_lock && !m_lockq;
        if (t[2]) m_pr = 1;
        else if (rise) m_pr = 0;
        m_lockq = periodic_read_lock;
        m_urg  = (m_pend >= URG);
        m_areq = (m_pend != 0);
        m_zreq = m_zq && !m_urg;
        m_preq = m_pr && !m_urg && !periodic_read_lock;
    endtask

    task automatic compare_all();
        check_val("autoref_req",  32'(autoref_req),  32'(m_areq));
        check_val("zq_req",       32'(zq_req),       32'(m_zreq));
        check_val("pr_rd_req",    32'(pr_rd_req),    32'(m_preq));
        check_val("ref_pending",  32'(ref_pending),  32'(m_pend));
        check_val("ref_urgent",   32'(ref_urgent),   32'(m_urg));
        check_val("ref_overflow", 32'(ref_overflow), 32'(m_ovf));
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset applied between edges; outputs must clear before any edge.
    task automatic do_reset();
        autoref_ack = 1'b0; zq_ack = 1'b0; periodic_read_lock = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check_val("rst_autoref_req", 32'(autoref_req), 32'd0);
        check_val("rst_ref_pending", 32'(ref_pending), 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int zq_high;
        bit reached;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Refresh tick and ack with trefi=100.
        trefi = 28'd100;
        step();
        maint_en = 1'b1;
        run(99);
        check_val("ref100_before", 32'(autoref_req), 32'd0);
        step();
        check_val("ref100_req", 32'(autoref_req), 32'd1);
        run(5);
        autoref_ack = 1'b1;
        step();
        autoref_ack = 1'b0;
        check_val("ref100_drop", 32'(autoref_req), 32'd0);
        check_val("ref100_pend", 32'(ref_pending), 32'd0);

        // Saturation and overflow.
        do_reset();
        trefi = 28'd10; maint_en = 1'b1;
        run(120);
        check_val("sat_pend", 32'(ref_pending), 32'd8);
        check_val("sat_ovf",  32'(ref_overflow), 32'd1);
        maint_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            autoref_ack = 1'b1; step();
            autoref_ack = 1'b0; step();
        end
        check_val("drain_pend", 32'(ref_pending), 32'd0);
        check_val("drain_ovf",  32'(ref_overflow), 32'd1);
        check_val("drain_req",  32'(autoref_req), 32'd0);

        // Urgent masking of ZQ.
        do_reset();
        trefi = 28'd10; tzq_int = 28'd5; maint_en = 1'b1;
        for (int i = 0; i < 200 && m_pend < 5; i++) step();
        check_val("urg_pre_pend", 32'(ref_pending), 32'd5);
        check_val("urg_pre_zq",   32'(zq_req), 32'(ZQ_ON));
        for (int i = 0; i < 200 && m_pend < 6; i++) step();
        maint_en = 1'b0;
        check_val("urg_pend",   32'(ref_pending), 32'd6);
        check_val("urg_flag",   32'(ref_urgent), 32'd1);
        check_val("urg_zq_off", 32'(zq_req), 32'd0);
        autoref_ack = 1'b1; step(); step();
        autoref_ack = 1'b0;
        check_val("urg_rel_pend", 32'(ref_pending), 32'd4);
        check_val("urg_rel_zq",   32'(zq_req), 32'(ZQ_ON));
        tzq_int = '0;

        // Tick and ack in the same cycle.
        do_reset();
        trefi = 28'd10; maint_en = 1'b1;
        for (int i = 0; i < 200 && m_pend < 3; i++) step();
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (m_tick(0)) reached = 1'b1;
            else step();
        end
        check_val("sim_tick_found", 32'(reached), 32'd1);
        autoref_ack = 1'b1;
        step();
        autoref_ack = 1'b0;
        check_val("sim_pend", 32'(ref_pending), 32'd3);
        check_val("sim_req",  32'(autoref_req), 32'd1);

        // Periodic-read lock handshake.
        do_reset();
        trefi = '0; tpr_int = 28'd10; maint_en = 1'b1;
        for (int i = 0; i < 50 && !m_preq; i++) step();
        check_val("pr_req", 32'(pr_rd_req), 32'd1);
        tpr_int = '0;
        periodic_read_lock = 1'b1;
        step();
        check_val("pr_lock_drop", 32'(pr_rd_req), 32'd0);
        run(20);
        periodic_read_lock = 1'b0;
        run(10);
        check_val("pr_after_unlock", 32'(pr_rd_req), 32'd0);

        // tzq_int=0 never produces zq_req.
        do_reset();
        trefi = 28'd7; tpr_int = 28'd9; tzq_int = '0; maint_en = 1'b1;
        zq_high = 0;
        for (int i = 0; i < 200; i++) begin
            autoref_ack = (($urandom % 3) == 0);
            step();
            if (zq_req) zq_high++;
        end
        autoref_ack = 1'b0;
        check_val("tzq0_never", 32'(zq_high), 32'd0);

        // maint_en dropped keeps serving pending refresh, then async reset mid-request.
        do_reset();
        trefi = 28'd10; tpr_int = '0; maint_en = 1'b1;
        run(15);
        maint_en = 1'b0;
        run(50);
        check_val("dis_req",  32'(autoref_req), 32'd1);
        check_val("dis_pend", 32'(ref_pending), 32'd1);
        do_reset();

        // Randomized traffic against the model.
        maint_en = 1'b1;
        trefi = 28'd13; tzq_int = 28'd29; tpr_int = 28'd17;
        for (int c = 0; c < 3000; c++) begin
            if (($urandom % 150) == 0) trefi   = CW'($urandom_range(0, 40));
            if (($urandom % 150) == 0) tzq_int = CW'($urandom_range(0, 60));
            if (($urandom % 150) == 0) tpr_int = CW'($urandom_range(0, 50));
            if (($urandom % 100) == 0) maint_en = ~maint_en;
            if (!maint_en && ($urandom % 20) == 0) maint_en = 1'b1;
            autoref_ack = (($urandom % 9) == 0);
            zq_ack      = (($urandom % 11) == 0);
            if (($urandom % 6) == 0) periodic_read_lock = ~periodic_read_lock;
            step();
        end
        autoref_ack = 1'b0; zq_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
